// File: rtl/mux_rr_stream_if.sv
// Handshake bundle between N producer channels, the stream mux and one consumer.
// The master side drives the producer inputs and consumer ready; the slave side is the mux.
interface mux_rr_stream_if #(
   parameter int N = 16,
   parameter int W = 8
);
   localparam int SW = (N > 1) ? $clog2(N) : 1;

   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic           mode;
   logic [SW-1:0]  sel;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_chan;
   logic           out_valid;
   logic           out_ready;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );
endinterface

// File: rtl/mux_rr_stream.sv
// N:1 streaming multiplexer with manual or round-robin channel selection and a
// registered output beat; ready is granted to at most one input per cycle.
module mux_rr_stream #(
   parameter int N = 16,
   parameter int W = 8
) (
   input  logic          clk,
   input  logic          rst,
   mux_rr_stream_if.slave bus
);
   localparam int SW = (N > 1) ? $clog2(N) : 1;

   logic [W-1:0]  r_out_data;
   logic [SW-1:0] r_out_chan;
   logic          r_out_valid;
   logic [SW-1:0] r_rr_ptr;

   logic          w_load_en;
   logic          w_found;
   logic [SW-1:0] w_grant;
   logic [SW:0]   w_sum;
   logic [N-1:0]  w_ready;
   logic          w_xfer;

   assign w_load_en = !r_out_valid || bus.out_ready;

   // Round-robin search walks rr_ptr+1 .. rr_ptr+N modulo N; first valid wins.
   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      w_sum   = '0;
      if (bus.mode) begin
         for (int k = 1; k <= N; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (SW+1)'(k);
            if (w_sum >= (SW+1)'(N))
               w_sum = w_sum - (SW+1)'(N);
            if (!w_found && bus.in_valid[w_sum[SW-1:0]]) begin
               w_found = 1'b1;
               w_grant = w_sum[SW-1:0];
            end
         end
      end else if (int'(bus.sel) < N && bus.in_valid[bus.sel]) begin
         w_found = 1'b1;
         w_grant = bus.sel;
      end
   end

   // Reset masks ready so no producer sees a transfer that the register ignores.
   always_comb begin
      w_ready = '0;
      if (!rst && w_load_en && w_found)
         w_ready[w_grant] = 1'b1;
   end

   assign w_xfer = w_load_en && w_found;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_chan  <= '0;
         r_rr_ptr    <= SW'(N - 1);
      end else if (w_load_en) begin
         if (w_xfer) begin
            r_out_data  <= bus.in_data[w_grant*W +: W];
            r_out_chan  <= w_grant;
            r_out_valid <= 1'b1;
            if (bus.mode)
               r_rr_ptr <= w_grant;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.out_data  = r_out_data;
   assign bus.out_chan  = r_out_chan;
   assign bus.out_valid = r_out_valid;
endmodule
